// File: rtl/fwht_pkg.sv
// Shared definitions for the Walsh-Hadamard transform blocks: FSM states,
// default geometry and the round-half-up constant used by the inverse path.
package fwht_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_LOG2N = 3;

    // Half of the 2^LOG2N divisor, added before the arithmetic shift.
    function automatic int round_const(input int log2n);
        return 1 << (log2n - 1);
    endfunction

endpackage

// File: rtl/iwht_stage.sv
// One single-delay-feedback butterfly stage of the streaming inverse WHT.
// Data, valid and SOF move through a D-deep delay line on every advance.
module iwht_stage
    import fwht_pkg::*;
#(
    parameter int IW    = DEF_WIDTH,
    parameter int D     = 1,
    parameter int P     = 0,
    parameter int LOG2N = DEF_LOG2N
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_adv,
    input  logic signed [IW-1:0]    i_data,
    input  logic                    i_valid,
    input  logic                    i_sof,
    input  logic [LOG2N-1:0]        adv_ctr,
    output logic signed [IW:0]      o_data,
    output logic                    o_valid,
    output logic                    o_sof
);

    localparam int PB = $clog2(D);

    logic signed [IW:0] dl [D];
    logic [D-1:0]       vl;
    logic [D-1:0]       sl;
    logic signed [IW:0] head;
    logic signed [IW:0] in_ext;
    logic               phase;

    assign in_ext = (IW + 1)'(i_data);
    assign head   = dl[D-1];
    // Phase is taken relative to when this stage's first sample arrives.
    assign phase  = 1'((adv_ctr - LOG2N'(P)) >> PB);

    // NOTE: the delay line is explicitly cleared in reset so a discarded
    // partial frame cannot leak stored differences into the next frame.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < D; i++) dl[i] <= '0;
            vl <= '0;
            sl <= '0;
        end else if (i_adv) begin
            dl[0] <= phase ? head - in_ext : in_ext;
            vl[0] <= i_valid;
            sl[0] <= i_sof;
            for (int i = 1; i < D; i++) begin
                dl[i] <= dl[i-1];
                vl[i] <= vl[i-1];
                sl[i] <= sl[i-1];
            end
        end
    end

    assign o_data  = phase ? head + in_ext : head;
    assign o_valid = vl[D-1];
    assign o_sof   = sl[D-1];

endmodule

// File: rtl/iwht_stream.sv
// Streaming N-point inverse fast Walsh-Hadamard transform: Hadamard-ordered
// coefficients in, natural-order samples out, scaled by 1/N round-half-up.
module iwht_stream
    import fwht_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LOG2N = DEF_LOG2N
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic signed [WIDTH-1:0] i_data,
    input  logic                    i_ce,
    output logic                    o_ready,
    output logic signed [WIDTH-1:0] o_data,
    output logic                    o_valid,
    output logic                    o_sof
);

    localparam int N  = 1 << LOG2N;
    localparam int AW = WIDTH + LOG2N;
    localparam logic signed [AW:0] RND = (AW + 1)'(round_const(LOG2N));

    state_t                  state;
    state_t                  state_nxt;
    logic [LOG2N-1:0]        adv_ctr;
    logic                    adv;
    logic                    accept;
    logic signed [WIDTH-1:0] in_data;
    logic signed [AW:0]      rnd_sum;

    // Stage-to-stage links, sign-extended to the widest stage.
    logic signed [AW-1:0]    stg_data  [LOG2N+1];
    logic                    stg_valid [LOG2N+1];
    logic                    stg_sof   [LOG2N+1];

    assign o_ready = (state != ST_FLUSH);
    assign accept  = i_ce && o_ready;

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nxt = state;
        adv       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    adv       = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // adv_ctr is only 0 in RUN right after a frame has completed.
                if (accept) adv = 1'b1;
                else if (adv_ctr == '0) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                adv = 1'b1;
                if (adv_ctr == '1) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign in_data      = accept ? i_data : '0;
    assign stg_data[0]  = AW'(in_data);
    assign stg_valid[0] = accept;
    assign stg_sof[0]   = accept && (adv_ctr == '0);

    for (genvar s = 0; s < LOG2N; s++) begin : g_stage
        localparam int IW = WIDTH + s;
        localparam int D  = N >> (s + 1);

        logic signed [IW:0] st_out;

        iwht_stage #(
            .IW    (IW),
            .D     (D),
            .P     (N - 2 * D),
            .LOG2N (LOG2N)
        ) u_stage (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_adv   (adv),
            .i_data  (IW'(stg_data[s])),
            .i_valid (stg_valid[s]),
            .i_sof   (stg_sof[s]),
            .adv_ctr (adv_ctr),
            .o_data  (st_out),
            .o_valid (stg_valid[s+1]),
            .o_sof   (stg_sof[s+1])
        );

        assign stg_data[s+1] = AW'(st_out);
    end

    assign rnd_sum = (AW + 1)'(stg_data[LOG2N]) + RND;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= ST_IDLE;
            adv_ctr <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
        end else begin
            state   <= state_nxt;
            o_valid <= adv && stg_valid[LOG2N];
            o_sof   <= adv && stg_valid[LOG2N] && stg_sof[LOG2N];
            if (adv) begin
                adv_ctr <= adv_ctr + LOG2N'(1);
                o_data  <= WIDTH'(rnd_sum >>> LOG2N);
            end
        end
    end

endmodule

// File: doc/iwht_stream.md
# iwht_stream

Streaming N-point inverse fast Walsh–Hadamard transform. It consumes one Hadamard-ordered coefficient frame, as produced by the forward FWHT pipeline's last stage. It emits the reconstructed samples in natural order, scaled by 1/N with round-half-up. It sits at the receive end of the transform path and closes the forward/inverse loop.

## Interface
- `WIDTH`, 16: signed sample width, for both input coefficients and output samples.
- `LOG2N`, 3: log2 of the frame length N. Legal range is 1..8.
- `i_clk`  in  1  rising-edge clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_data`  in  WIDTH  signed coefficient.
- `i_ce`  in  1  input strobe. A sample is accepted when `i_ce && o_ready`.
- `o_ready`  out  1  block can accept input. Low only in FLUSH.
- `o_data`  out  WIDTH  signed reconstructed sample, registered.
- `o_valid`  out  1  `o_data` is valid this cycle.
- `o_sof`  out  1  marks output sample 0 of a frame; qualified by `o_valid`.

## Operation
**Control FSM.** There is one FSM with three states: IDLE, RUN and FLUSH. An advance counter `adv_ctr` (LOG2N bits, wraps mod N) increments on every pipeline advance.
- **IDLE:** the pipeline holds.
  - An accepted sample goes to RUN and advances.
- **RUN:** the pipeline advances only on an accepted sample.
  - `i_ce` low stalls the pipeline with no state change.
  - After accepting the sample with `adv_ctr==N-1`: go to RUN if `i_ce` is high on the next cycle (back-to-back frame), else go to FLUSH.
- **FLUSH:** the pipeline advances every cycle with zero data marked invalid. `i_ce` is ignored (`o_ready=0`).
  - After N advances, `adv_ctr` returns to 0 and the FSM goes to IDLE.

**Datapath.** The datapath is LOG2N butterfly stages in order, with D = N/2, N/4, …, 1.
- Stage phase is bit log2(D) of (`adv_ctr` − P) mod N, where P is the sum of the delays of the preceding stages.
- Phase 0: the input is written to the delay line, and the stage outputs the delay-line head (the stored differences).
- Phase 1: the stage outputs head + input, and head − input is written to the delay line.
- Each stage grows the width by 1 bit. The last stage is WIDTH+LOG2N bits wide.

**Scaling.** The output is (acc + 2^(LOG2N−1)) >>> LOG2N, truncated to WIDTH bits. The result always fits, so there is no saturation logic.

**Valid/SOF tracking.** Valid and SOF bits travel through per-stage D-deep shift registers that advance with the data. The SOF bit is set on the input sample with `adv_ctr==0`.

**Reset.**
- Clears the FSM (to IDLE), `adv_ctr`, all valid/SOF bits, all delay-line data, and the output register.
- Reset mid-frame discards the partial frame. There is no output from it after reset.

## Timing
- Reset values: `o_data=0`, `o_valid=0`, `o_sof=0`, `o_ready=1`.
- Latency is N pipeline advances from acceptance of a sample to its output at the `o_data` register:
  - total stage delay is N−1;
  - plus one output register cycle.
- With continuous input, output sample k of a frame appears exactly N cycles after input sample k.
- Stalls in RUN delay the outputs by the stall length. `o_valid` is low during stalls.
- Back-to-back frames stream with no bubble. Frame f+1 outputs follow frame f outputs contiguously.
- The last output of an isolated frame appears during FLUSH. `o_ready` rises the cycle after the Nth flush advance.
- If `i_ce` and `i_reset` are both high, reset wins and the sample is dropped.

## Structure
- **Shared package `fwht_pkg`:**
  - FSM state enum (IDLE/RUN/FLUSH);
  - default WIDTH and LOG2N;
  - a function for the rounding constant 2^(LOG2N−1).
- **Sub-module `iwht_stage`:**
  - parameters: IW (input width), D (delay), P (phase offset);
  - ports: i_clk, i_reset, i_adv, i_data, i_valid, i_sof, `adv_ctr`, o_data (IW+1 bits), o_valid, o_sof;
  - instantiated LOG2N times in a generate loop.
- The top level holds the FSM, `adv_ctr`, the rounding/shift, and the output register.

## Test plan
- **Impulse:** LOG2N=2, WIDTH=16, frame [4,0,0,0] with continuous `i_ce` → outputs [1,1,1,1], first output 4 cycles after first input, `o_sof` on the first output.
- **Mixed values:** LOG2N=2, frame [10,2,−2,2] → outputs [3,1,3,3] in that order.
- **Rounding:** LOG2N=2, frame [2,0,0,0] → [1,1,1,1]; frame [1,0,0,0] → [0,0,0,0]; frame [−2,0,0,0] → [0,0,0,0].
- **Back-to-back and stalls:**
  - two frames [4,0,0,0] then [10,2,−2,2] with no gap → 8 contiguous valid outputs;
  - repeat with `i_ce` low for 3 cycles mid-frame → same values, `o_valid` gap of 3 cycles.
- **Flush handshake:** a single frame then `i_ce` held high → `o_ready` low for 4 cycles after the last input, extra `i_ce` samples ignored, next frame accepted from `adv_ctr=0`.
- **Reset mid-frame:** assert `i_reset` after 2 of 4 samples → no outputs emitted. The next full frame [4,0,0,0] yields [1,1,1,1] with correct `o_sof`.
